// File: rtl/vadd_stream.sv
// Streaming per-lane add/sub/saturating-add with a 2-entry result FIFO and
// free-running cycle / handshake counters.
module vadd_stream #(
    parameter int unsigned LANES = 1,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [WIDTH*LANES-1:0]   in_a,
    input  logic [WIDTH*LANES-1:0]   in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*LANES-1:0]   out_y,
    output logic [LANES-1:0]         out_flag,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         txn_count
);

    localparam int unsigned DW = WIDTH * LANES;
    localparam logic [WIDTH-1:0] UMAX = '1;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDS = 2'b10,
        OP_ADDU = 2'b11
    } op_e;

    logic [DW-1:0]    res_y_c;
    logic [LANES-1:0] res_flag_c;

    logic [DW-1:0]    head_y_q, head_y_d, tail_y_q, tail_y_d;
    logic [LANES-1:0] head_f_q, head_f_d, tail_f_q, tail_f_d;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, txn_q, txn_d;
    logic             push_c, pop_c;

    // Per-lane arithmetic; lanes never share a carry.
    always_comb begin
        logic [WIDTH-1:0] a_l, b_l, y_l;
        logic [WIDTH:0]   sum_l, dif_l;
        logic             f_l, ovp_l, ovn_l;
        res_y_c    = '0;
        res_flag_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            a_l   = in_a[WIDTH*i +: WIDTH];
            b_l   = in_b[WIDTH*i +: WIDTH];
            sum_l = {1'b0, a_l} + {1'b0, b_l};
            dif_l = {1'b0, a_l} - {1'b0, b_l};
            ovp_l = ~a_l[WIDTH-1] & ~b_l[WIDTH-1] &  sum_l[WIDTH-1];
            ovn_l =  a_l[WIDTH-1] &  b_l[WIDTH-1] & ~sum_l[WIDTH-1];
            y_l   = sum_l[WIDTH-1:0];
            f_l   = 1'b0;
            case (op_e'(in_op))
                OP_ADD: begin
                    y_l = sum_l[WIDTH-1:0];
                    f_l = sum_l[WIDTH];
                end
                OP_SUB: begin
                    y_l = dif_l[WIDTH-1:0];
                    f_l = dif_l[WIDTH];
                end
                OP_ADDS: begin
                    y_l = ovp_l ? SMAX : (ovn_l ? SMIN : sum_l[WIDTH-1:0]);
                    f_l = ovp_l | ovn_l;
                end
                default: begin
                    y_l = sum_l[WIDTH] ? UMAX : sum_l[WIDTH-1:0];
                    f_l = sum_l[WIDTH];
                end
            endcase
            res_y_c[WIDTH*i +: WIDTH] = y_l;
            res_flag_c[i]             = f_l;
        end
    end

    assign push_c = in_valid & in_ready_q;
    assign pop_c  = out_valid_q & out_ready;

    // Shift FIFO: the head entry drives the outputs directly.
    always_comb begin
        head_y_d    = head_y_q;
        head_f_d    = head_f_q;
        tail_y_d    = tail_y_q;
        tail_f_d    = tail_f_q;
        count_d     = count_q;
        cyc_d       = cyc_q + CNT_W'(1);
        txn_d       = pop_c ? txn_q + CNT_W'(1) : txn_q;
        case (count_q)
            2'd0: begin
                if (push_c) begin
                    head_y_d = res_y_c;
                    head_f_d = res_flag_c;
                    count_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push_c && pop_c) begin
                    head_y_d = res_y_c;
                    head_f_d = res_flag_c;
                end else if (push_c) begin
                    tail_y_d = res_y_c;
                    tail_f_d = res_flag_c;
                    count_d  = 2'd2;
                end else if (pop_c) begin
                    count_d  = 2'd0;
                end
            end
            default: begin
                if (pop_c) begin
                    head_y_d = tail_y_q;
                    head_f_d = tail_f_q;
                    count_d  = 2'd1;
                end
            end
        endcase
        in_ready_d  = (count_d != 2'd2);
        out_valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_y_q    <= '0;
            head_f_q    <= '0;
            tail_y_q    <= '0;
            tail_f_q    <= '0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cyc_q       <= '0;
            txn_q       <= '0;
        end else begin
            head_y_q    <= head_y_d;
            head_f_q    <= head_f_d;
            tail_y_q    <= tail_y_d;
            tail_f_q    <= tail_f_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cyc_q       <= cyc_d;
            txn_q       <= txn_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_y       = head_y_q;
    assign out_flag    = head_f_q;
    assign cycle_count = cyc_q;
    assign txn_count   = txn_q;

endmodule
